// File: rtl/pipe_hazard_control.sv
// Decode-stage control: instruction decode, forwarding selects, delayed jump/branch.
// Load-use stall generation is compiled in only when LOAD_USE_STALL_EN is defined.
module pipe_hazard_control #(
    parameter int  REG_AW    = 5,
    parameter int  FWD_DEPTH = 3,
    parameter int  BR_DELAY  = 1,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instruction,
    output logic             RegDst,
    output logic             RegWr,
    output logic             ALUsrc,
    output logic             MemWr,
    output logic             MemToReg,
    output logic [1:0]       ALUcntrl,
    output logic [25:0]      target_inst,
    output logic             jump_del,
    output logic             branch_del,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic             stall,
    output logic             illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BLTZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NOR  = 2'b10;
    localparam logic [1:0] ALU_SLTU = 2'b11;

    typedef struct packed {
        logic              wr_en;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } hist_t;

    logic [5:0]          opcode;
    logic [5:0]          func;
    logic [REG_AW-1:0]   src_a;
    logic [REG_AW-1:0]   src_b;
    logic [REG_AW-1:0]   rd;
    logic                known;
    logic                jump_now;
    logic                branch_now;
    logic                load_now;
    logic                uses_a;
    logic                uses_b;
    hist_t               dec_entry;
    hist_t               hist [FWD_DEPTH];
    logic [BR_DELAY-1:0] jump_chain;
    logic [BR_DELAY-1:0] branch_chain;
    logic                unused_is_load;

    assign opcode = instruction[31:26];
    assign func   = instruction[5:0];
    assign src_a  = REG_AW'(instruction[25:21]);
    assign src_b  = REG_AW'(instruction[20:16]);
    assign rd     = REG_AW'(instruction[15:11]);

    // Everything defaults to 0 so bubbles, illegal encodings and don't-cares never drive X.
    // bltz tests the sign of rs directly, so its ALU op is a don't-care and stays ADD (0).
    always_comb begin
        RegDst      = 1'b0;
        RegWr       = 1'b0;
        ALUsrc      = 1'b0;
        MemWr       = 1'b0;
        MemToReg    = 1'b0;
        ALUcntrl    = ALU_ADD;
        target_inst = '0;
        known       = 1'b0;
        jump_now    = 1'b0;
        branch_now  = 1'b0;
        load_now    = 1'b0;
        uses_a      = 1'b0;
        uses_b      = 1'b0;
        if (instr_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    case (func)
                        FN_JR: begin
                            known      = 1'b1;
                            jump_now   = 1'b1;
                            branch_now = 1'b1;
                            uses_a     = 1'b1;
                        end
                        FN_SUBU, FN_NOR, FN_SLTU: begin
                            known    = 1'b1;
                            RegDst   = 1'b1;
                            RegWr    = 1'b1;
                            uses_a   = 1'b1;
                            uses_b   = 1'b1;
                            ALUcntrl = (func == FN_SUBU) ? ALU_SUB :
                                       (func == FN_NOR)  ? ALU_NOR : ALU_SLTU;
                        end
                        default: known = 1'b0;
                    endcase
                end
                OP_BLTZ: begin
                    known      = 1'b1;
                    branch_now = 1'b1;
                    uses_a     = 1'b1;
                end
                OP_J: begin
                    known       = 1'b1;
                    jump_now    = 1'b1;
                    target_inst = instruction[25:0];
                end
                OP_ADDI: begin
                    known  = 1'b1;
                    RegWr  = 1'b1;
                    ALUsrc = 1'b1;
                    uses_a = 1'b1;
                end
                OP_LW: begin
                    known    = 1'b1;
                    RegWr    = 1'b1;
                    ALUsrc   = 1'b1;
                    MemToReg = 1'b1;
                    load_now = 1'b1;
                    uses_a   = 1'b1;
                end
                OP_SW: begin
                    known  = 1'b1;
                    MemWr  = 1'b1;
                    ALUsrc = 1'b1;
                    uses_a = 1'b1;
                    uses_b = 1'b1;
                end
                default: known = 1'b0;
            endcase
        end
        illegal = instr_valid && !known;
    end

    always_comb begin
        dec_entry.wr_en   = RegWr;
        dec_entry.dest    = RegDst ? rd : src_b;
        dec_entry.is_load = load_now;
    end

    // A stall pushes a bubble instead of the held decode entry; older stages always advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FWD_DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else begin
            hist[0] <= stall ? '0 : dec_entry;
            for (int i = 1; i < FWD_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            jump_chain   <= '0;
            branch_chain <= '0;
        end else begin
            jump_chain[0]   <= jump_now && !stall;
            branch_chain[0] <= branch_now && !stall;
            for (int i = 1; i < BR_DELAY; i++) begin
                jump_chain[i]   <= jump_chain[i-1];
                branch_chain[i] <= branch_chain[i-1];
            end
        end
    end

    assign jump_del   = jump_chain[BR_DELAY-1];
    assign branch_del = branch_chain[BR_DELAY-1];

    // Scanning from the oldest stage down lets the youngest matching writer win.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (uses_a && hist[k-1].wr_en && (hist[k-1].dest != '0) && (hist[k-1].dest == src_a)) begin
                fwd_a_sel = SEL_W'(k);
            end
            if (uses_b && hist[k-1].wr_en && (hist[k-1].dest != '0) && (hist[k-1].dest == src_b)) begin
                fwd_b_sel = SEL_W'(k);
            end
        end
    end

`ifdef LOAD_USE_STALL_EN
    logic load_hazard;

    // The bubble inserted by the stall clears stage 1, so the stall lasts a single cycle.
    always_comb begin
        load_hazard = hist[0].is_load && hist[0].wr_en && (hist[0].dest != '0) &&
                      ((uses_a && (hist[0].dest == src_a)) || (uses_b && (hist[0].dest == src_b)));
        stall       = rst && load_hazard;
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        unused_is_load = 1'b0;
        for (int i = 0; i < FWD_DEPTH; i++) begin
            unused_is_load = unused_is_load ^ hist[i].is_load;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_control.sv
// Self-checking bench for pipe_hazard_control: directed steps, then random traffic
// compared against a queue-based reference model (honours LOAD_USE_STALL_EN).
module tb_pipe_hazard_control;

    localparam int FWD_DEPTH = 3;
    localparam int BR_DELAY  = 2;
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic [31:0]      instruction;
    logic             RegDst;
    logic             RegWr;
    logic             ALUsrc;
    logic             MemWr;
    logic             MemToReg;
    logic [1:0]       ALUcntrl;
    logic [25:0]      target_inst;
    logic             jump_del;
    logic             branch_del;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic             stall;
    logic             illegal;

    int checks   = 0;
    int errors   = 0;
    int step_num = 0;

    typedef struct {
        bit we;
        int dest;
        bit ld;
    } ent_t;

    typedef struct {
        bit reg_dst;
        bit reg_wr;
        bit alu_src;
        bit mem_wr;
        bit mem_to_reg;
        int alu;
        bit jump;
        bit branch;
        bit ill;
        int target;
        bit ua;
        bit ub;
        int rs;
        int rt;
        int dest;
        bit ld;
    } dec_t;

    ent_t hist_q[$];
    bit   jq[$];
    bit   bq[$];

    pipe_hazard_control #(
        .REG_AW   (5),
        .FWD_DEPTH(FWD_DEPTH),
        .BR_DELAY (BR_DELAY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .RegDst     (RegDst),
        .RegWr      (RegWr),
        .ALUsrc     (ALUsrc),
        .MemWr      (MemWr),
        .MemToReg   (MemToReg),
        .ALUcntrl   (ALUcntrl),
        .target_inst(target_inst),
        .jump_del   (jump_del),
        .branch_del (branch_del),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall      (stall),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference decode straight from the instruction table.
    function automatic dec_t decode(input bit v, input logic [31:0] ins);
        dec_t d;
        int   op;
        int   fn;
        int   rd;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        rd = int'(ins[15:11]);
        d.reg_dst = 0; d.reg_wr = 0; d.alu_src = 0; d.mem_wr = 0; d.mem_to_reg = 0;
        d.alu = 0; d.jump = 0; d.branch = 0; d.ill = 0; d.target = 0;
        d.ua = 0; d.ub = 0; d.ld = 0;
        d.rs = int'(ins[25:21]);
        d.rt = int'(ins[20:16]);
        if (v) begin
            if (op == 'h08) begin
                d.reg_wr = 1; d.alu_src = 1; d.ua = 1;
            end else if (op == 'h01) begin
                d.branch = 1; d.ua = 1;
            end else if (op == 'h02) begin
                d.jump = 1; d.target = int'(ins[25:0]);
            end else if (op == 'h23) begin
                d.reg_wr = 1; d.alu_src = 1; d.mem_to_reg = 1; d.ld = 1; d.ua = 1;
            end else if (op == 'h2B) begin
                d.mem_wr = 1; d.alu_src = 1; d.ua = 1; d.ub = 1;
            end else if (op == 0 && fn == 'h08) begin
                d.jump = 1; d.branch = 1; d.ua = 1;
            end else if (op == 0 && (fn == 'h23 || fn == 'h27 || fn == 'h2B)) begin
                d.reg_dst = 1; d.reg_wr = 1; d.ua = 1; d.ub = 1;
                d.alu = (fn == 'h23) ? 1 : (fn == 'h27) ? 2 : 3;
            end else begin
                d.ill = 1;
            end
        end
        d.dest = d.reg_dst ? rd : d.rt;
        return d;
    endfunction

    // Youngest in-flight writer of src, counted from stage 1.
    function automatic int fwd_of(input int src);
        for (int i = 0; i < hist_q.size(); i++) begin
            if (src != 0 && hist_q[i].we && hist_q[i].dest == src) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] ins;
        int          sel;
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        imm = 16'($urandom);
        tgt = 26'($urandom);
        sel = int'($urandom_range(0, 11));
        case (sel)
            0:       ins = {6'h08, rs, rt, imm};
            1:       ins = {6'h01, rs, 5'd0, imm};
            2:       ins = {6'h02, tgt};
            3, 4:    ins = {6'h23, rs, rt, imm};
            5:       ins = {6'h2B, rs, rt, imm};
            6:       ins = {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
            7:       ins = {6'h00, rs, rt, rd, 5'd0, 6'h23};
            8:       ins = {6'h00, rs, rt, rd, 5'd0, 6'h27};
            9:       ins = {6'h00, rs, rt, rd, 5'd0, 6'h2B};
            10:      ins = {6'h3F, rs, rt, imm};
            default: ins = {6'h00, rs, rt, rd, 5'd0, 6'h3E};
        endcase
        return ins;
    endfunction

    task automatic reset_model();
        ent_t z;
        z.we = 0; z.dest = 0; z.ld = 0;
        hist_q.delete();
        jq.delete();
        bq.delete();
        repeat (FWD_DEPTH) hist_q.push_back(z);
        repeat (BR_DELAY) begin
            jq.push_back(1'b0);
            bq.push_back(1'b0);
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL step %0d %s: observed %0h expected %0h", step_num, name, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input bit r, input bit v, input logic [31:0] ins);
        dec_t d;
        ent_t e;
        bit   exp_stall;
        step_num++;
        rst         = r;
        instr_valid = v;
        instruction = ins;
        #2;
        d = decode(v, ins);
        exp_stall = 0;
`ifdef LOAD_USE_STALL_EN
        if (r && hist_q[0].ld && hist_q[0].we && hist_q[0].dest != 0 &&
            ((d.ua && d.rs == hist_q[0].dest) || (d.ub && d.rt == hist_q[0].dest)))
            exp_stall = 1;
`endif
        check_output("RegDst",      32'(RegDst),      32'(d.reg_dst));
        check_output("RegWr",       32'(RegWr),       32'(d.reg_wr));
        check_output("ALUsrc",      32'(ALUsrc),      32'(d.alu_src));
        check_output("MemWr",       32'(MemWr),       32'(d.mem_wr));
        check_output("MemToReg",    32'(MemToReg),    32'(d.mem_to_reg));
        check_output("ALUcntrl",    32'(ALUcntrl),    32'(d.alu));
        check_output("target_inst", 32'(target_inst), 32'(d.target));
        check_output("illegal",     32'(illegal),     32'(d.ill));
        check_output("fwd_a_sel",   32'(fwd_a_sel),   32'(d.ua ? fwd_of(d.rs) : 0));
        check_output("fwd_b_sel",   32'(fwd_b_sel),   32'(d.ub ? fwd_of(d.rt) : 0));
        check_output("stall",       32'(stall),       32'(exp_stall));
        check_output("jump_del",    32'(jump_del),    32'(jq[BR_DELAY-1]));
        check_output("branch_del",  32'(branch_del),  32'(bq[BR_DELAY-1]));
        @(posedge clk);
        #1;
        if (!r) begin
            reset_model();
        end else begin
            e.we   = exp_stall ? 1'b0 : d.reg_wr;
            e.dest = d.dest;
            e.ld   = exp_stall ? 1'b0 : d.ld;
            hist_q.push_front(e);
            void'(hist_q.pop_back());
            jq.push_front(d.jump && !exp_stall);
            void'(jq.pop_back());
            bq.push_front(d.branch && !exp_stall);
            void'(bq.pop_back());
        end
    endtask

    initial begin
        rst         = 1'b0;
        instr_valid = 1'b1;
        instruction = 32'h00221823;
        @(posedge clk);
        #1;
        reset_model();

        // reset held with subu $3,$1,$2 in decode
        apply_stimulus(0, 1, 32'h00221823);
        apply_stimulus(0, 1, 32'h00221823);

        // forward from stage 1, then from stage 3 through two bubbles
        apply_stimulus(1, 1, 32'h20010005);
        apply_stimulus(1, 1, 32'h00221823);
        apply_stimulus(1, 1, 32'h20010005);
        apply_stimulus(1, 0, 32'h00000000);
        apply_stimulus(1, 0, 32'h20010005);
        apply_stimulus(1, 1, 32'h00221823);

        // load-use: lw $4 then subu $5,$4,$4
        apply_stimulus(1, 1, 32'h8C040000);
        apply_stimulus(1, 1, 32'h00842823);
`ifdef LOAD_USE_STALL_EN
        apply_stimulus(1, 1, 32'h00842823);
`endif

        // j with delayed flag, then jr
        apply_stimulus(1, 1, 32'h08000010);
        repeat (3) apply_stimulus(1, 0, 32'h00000000);
        apply_stimulus(1, 1, 32'h03E00008);
        repeat (3) apply_stimulus(1, 0, 32'h00000000);

        // illegal encoding and a writer of $0
        apply_stimulus(1, 1, 32'hFC000000);
        apply_stimulus(1, 1, 32'h00000823);
        apply_stimulus(1, 1, 32'h20000007);
        apply_stimulus(1, 1, 32'h00000823);

        // reset landing in the middle of a load-use hazard
        apply_stimulus(1, 1, 32'h8C040000);
        apply_stimulus(1, 1, 32'h00842823);
        apply_stimulus(0, 1, 32'h00842823);
        apply_stimulus(1, 1, 32'h00842823);

        // remaining opcodes: sw, nor, sltu, bltz
        apply_stimulus(1, 1, 32'h20020009);
        apply_stimulus(1, 1, 32'hAC220004);
        apply_stimulus(1, 1, 32'h00223027);
        apply_stimulus(1, 1, 32'h00C1382B);
        apply_stimulus(1, 1, 32'h04E0FFFE);
        repeat (2) apply_stimulus(1, 0, 32'h00000000);

        for (int i = 0; i < 300; i++) begin
            apply_stimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0), rand_instr());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
